r_ptr_and_empty: RTL and testbench
==================================

Name: r_ptr_and_empty

Overview:
- Read-side pointer and empty-flag logic for the asynchronous FIFO; the companion to the write-side pointer/full block.
- Lives entirely in the read clock domain.
- Holds the binary read count and drives the dual-port RAM read address.
- Publishes a Gray-coded read pointer for synchronisation into the write domain, and derives empty, almost-empty, fill level and underflow status from the synchronised write pointer.

Parameters:
- ADDR_W, 5, RAM address width. Depth = 2^ADDR_W = 32. Pointers are ADDR_W+1 = 6 bits.
- AE_THRESH, 2, almost_empty asserts when fill level <= AE_THRESH. Legal range 0..2^ADDR_W-1.

Ports:
- rd_clk, input, 1, read-domain clock. All logic on the rising edge.
- rd_rst_n, input, 1, synchronous active-low reset, sampled on rising rd_clk.
- rd_en, input, 1, read request. Accepted only when empty=0.
- rq2_wptr, input, ADDR_W+1, Gray write pointer, already two-flop synchronised into rd_clk. See Optional Feature.
- uf_clr, input, 1, clears the sticky underflow flag.
- rd_addr, output, ADDR_W, RAM read address = low ADDR_W bits of the binary read count.
- rd_ptr, output, ADDR_W+1, Gray-coded read pointer sent to the write domain.
- empty, output, 1, FIFO empty, registered.
- almost_empty, output, 1, level <= AE_THRESH, registered.
- rd_level, output, ADDR_W+1, number of words available, 0..2^ADDR_W, registered.
- underflow, output, 1, sticky flag: a read was attempted while empty.

Behaviour:
- Reset: all state updates on rising rd_clk when rd_rst_n=0, in any cycle, including mid-operation. Reset values: rd_bin=0, rd_addr=0, rd_ptr=0, empty=1, almost_empty=1, rd_level=0, underflow=0. Reset overrides rd_en and uf_clr.
- Read acceptance: rd_inc = rd_en & ~empty, using the registered empty.
- Pointer arithmetic:
  - rd_bin_next = rd_bin + rd_inc, modulo 2^(ADDR_W+1).
  - rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next.
  - rd_bin <= rd_bin_next. rd_ptr <= rd_gray_next. rd_addr = rd_bin[ADDR_W-1:0].
- Latency:
  - rd_addr points at the word currently at the FIFO head.
  - On an accepted read, rd_addr and rd_ptr advance on that same edge, so one cycle later.
  - RAM read latency is owned by the RAM, not by this block.
- Wrap-around: the binary count wraps from 2^(ADDR_W+1)-1 to 0. The MSB toggles every 2^ADDR_W reads. rd_ptr changes exactly one bit per accepted read, including at wrap.
- Empty: empty <= (rd_gray_next == rq2_wptr). Full Gray equality, MSB included.
  - The last read of the remaining data raises empty on the same edge the pointer advances.
  - empty deasserts no earlier than the edge after rq2_wptr changes. This conservative delay is inherent to the synchroniser.
- Level:
  - wbin = Gray-to-binary of rq2_wptr, where bit i = XOR of Gray bits [ADDR_W:i].
  - rd_level <= (wbin - rd_bin_next) mod 2^(ADDR_W+1).
  - almost_empty <= (that level <= AE_THRESH).
  - empty=1 implies rd_level=0 and almost_empty=1.
- Underflow:
  - Set when rd_en=1 and empty=1 in the same cycle. Pointers are unchanged in that case.
  - Cleared on the edge where uf_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous rd_en and a write-pointer update: both take effect in one evaluation. Level = new wbin minus new rd_bin.
- No state machine beyond the pointer registers. All outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro RD_INT_SYNC_EN.
- Defined:
  - rq2_wptr is treated as the raw write-domain Gray pointer.
  - The block adds an internal two-stage rd_clk synchroniser. Both stages reset to 0 on rd_rst_n=0.
  - All empty and level logic uses the second stage, which adds 2 rd_clk cycles of latency to empty deassertion and level increase.
- Undefined: no synchroniser. rq2_wptr is used directly, and the FIFO top instantiates the external sync.

Test Plan:
- Reset: rd_rst_n=0 for 2 cycles with rq2_wptr=6'b000101 and rd_en=1 -> rd_addr=0, rd_ptr=0, empty=1, almost_empty=1, rd_level=0, underflow=0.
- Fill then drain:
  - Stimulus: drive rq2_wptr=Gray(4)=6'b000110, then rd_en=1 for 4 cycles.
  - Required: empty=0, rd_level=4, almost_empty=0 before reads start.
  - Level sequence 3,2,1,0. almost_empty=1 from level 2 onward. empty=1 on the 4th read edge. rd_addr ends at 4, rd_ptr=6'b000110.
- Underflow:
  - Stimulus: rd_en=1 while empty=1 for 3 cycles.
  - Required: rd_addr and rd_ptr unchanged, underflow=1 and held.
  - Pulse uf_clr together with rd_en=1 -> underflow stays 1. Pulse uf_clr alone -> underflow=0.
- Wrap:
  - Stimulus: perform 64 reads, advancing rq2_wptr ahead each time.
  - Required: rd_bin wraps 63->0. rd_addr wraps 31->0 at read 32 and read 64. rd_ptr changes one bit per read. Gray 6'b100000 at read 63 returns to 0.
- Full level: rq2_wptr=Gray(32)=6'b110000 with rd_bin=0 -> rd_level=32, empty=0, almost_empty=0.
- Simultaneous events: rd_level=1, rd_en=1, and rq2_wptr advances by 1 on the same edge -> rd_level stays 1 and empty stays 0. With RD_INT_SYNC_EN defined, the same write advance reaches level 2 cycles later.

Source files
------------

// File: rtl/r_ptr_and_empty.sv
// Read-side FIFO pointer: binary count, RAM address, Gray pointer, empty/level/underflow; all outputs registered, advance on the accepting edge.
// Reads are accepted only while not empty; optional internal write-pointer synchroniser under RD_INT_SYNC_EN.
module r_ptr_and_empty #(
   parameter int ADDR_W    = 5,
   parameter int AE_THRESH = 2
) (
   input  logic              rd_clk,
   input  logic              rd_rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W:0]   rq2_wptr,
   input  logic              uf_clr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   rd_ptr,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   rd_level,
   output logic              underflow
);

   localparam int PW = ADDR_W + 1;
   localparam logic [ADDR_W:0] AE_LVL = PW'(AE_THRESH);

   logic [ADDR_W:0] wptr_s;

`ifdef RD_INT_SYNC_EN
   // Raw write-domain Gray pointer crosses here; stage two feeds empty/level.
   logic [ADDR_W:0] sync1_q, sync1_d;
   logic [ADDR_W:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = rq2_wptr;
      sync2_d = sync1_q;
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign wptr_s = sync2_q;
`else
   assign wptr_s = rq2_wptr;
`endif

   logic [ADDR_W:0] rd_bin_q, rd_bin_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] rd_level_q, rd_level_d;
   logic            empty_q, empty_d;
   logic            almost_empty_q, almost_empty_d;
   logic            underflow_q, underflow_d;
   logic            rd_inc;
   logic [ADDR_W:0] wbin;

   always_comb begin
      rd_inc   = rd_en & ~empty_q;
      rd_bin_d = rd_bin_q + {{ADDR_W{1'b0}}, rd_inc};
      rd_ptr_d = (rd_bin_d >> 1) ^ rd_bin_d;

      // Gray-to-binary: bit i is the XOR of Gray bits from the MSB down to i.
      wbin = '0;
      for (int i = 0; i < PW; i++) begin
         wbin[i] = ^(wptr_s >> i);
      end

      empty_d        = (rd_ptr_d == wptr_s);
      rd_level_d     = wbin - rd_bin_d;
      almost_empty_d = (rd_level_d <= AE_LVL);
      underflow_d    = (rd_en & empty_q) | (underflow_q & ~uf_clr);
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         rd_bin_q       <= '0;
         rd_ptr_q       <= '0;
         rd_level_q     <= '0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         underflow_q    <= 1'b0;
      end else begin
         rd_bin_q       <= rd_bin_d;
         rd_ptr_q       <= rd_ptr_d;
         rd_level_q     <= rd_level_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         underflow_q    <= underflow_d;
      end
   end

   assign rd_addr      = rd_bin_q[ADDR_W-1:0];
   assign rd_ptr       = rd_ptr_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign rd_level     = rd_level_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_r_ptr_and_empty.sv
// Scoreboard bench for r_ptr_and_empty: driver queues expected post-edge state, monitor compares after each rising edge.
module tb_r_ptr_and_empty;

   logic       rd_clk = 1'b0;
   logic       rd_rst_n = 1'b0;
   logic       rd_en = 1'b0;
   logic [5:0] rq2_wptr = '0;
   logic       uf_clr = 1'b0;
   logic [4:0] rd_addr;
   logic [5:0] rd_ptr;
   logic       empty;
   logic       almost_empty;
   logic [5:0] rd_level;
   logic       underflow;

`ifdef RD_INT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   localparam logic [5:0] M_ALL  = 6'h3f;
   localparam logic [5:0] M_NONE = 6'h00;

   typedef struct packed {
      logic [5:0] m;
      logic [4:0] addr;
      logic [5:0] ptr;
      logic       e;
      logic       ae;
      logic [5:0] lvl;
      logic       uf;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   r_ptr_and_empty #(.ADDR_W(5), .AE_THRESH(2)) dut (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .rd_en(rd_en), .rq2_wptr(rq2_wptr),
      .uf_clr(uf_clr), .rd_addr(rd_addr), .rd_ptr(rd_ptr), .empty(empty),
      .almost_empty(almost_empty), .rd_level(rd_level), .underflow(underflow)
   );

   always #5 rd_clk = ~rd_clk;

   function automatic logic [5:0] gray(input int b);
      logic [5:0] v;
      v = 6'(b);
      return (v >> 1) ^ v;
   endfunction

   task automatic cyc(input logic rstn, input logic en, input logic clr, input logic [5:0] w,
                      input logic [5:0] m, input logic [4:0] a, input logic [5:0] p,
                      input logic e, input logic ae, input logic [5:0] l, input logic uf,
                      input string nm);
      exp_t x;
      @(negedge rd_clk);
      rd_rst_n = rstn;
      rd_en    = en;
      uf_clr   = clr;
      rq2_wptr = w;
      x = '{m: m, addr: a, ptr: p, e: e, ae: ae, lvl: l, uf: uf};
      exp_q.push_back(x);
      name_q.push_back(nm);
   endtask

   task automatic idle(input logic [5:0] w, input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'b0, 1'b0, w, M_NONE, '0, '0, 1'b0, 1'b0, '0, 1'b0, "idle");
   endtask

   task automatic chk(input string nm, input string f, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, f, act, req, $time);
      end
   endtask

   // Monitor: one expectation per driven cycle, checked just after the edge.
   initial begin
      exp_t  x;
      string nm;
      forever begin
         @(posedge rd_clk);
         #1;
         if (exp_q.size() > 0) begin
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (x.m[0]) chk(nm, "rd_addr", int'(rd_addr), int'(x.addr));
            if (x.m[1]) chk(nm, "rd_ptr", int'(rd_ptr), int'(x.ptr));
            if (x.m[2]) chk(nm, "empty", int'(empty), int'(x.e));
            if (x.m[3]) chk(nm, "almost_empty", int'(almost_empty), int'(x.ae));
            if (x.m[4]) chk(nm, "rd_level", int'(rd_level), int'(x.lvl));
            if (x.m[5]) chk(nm, "underflow", int'(underflow), int'(x.uf));
         end
      end
   end

   initial begin
      logic [5:0] m;
      // Reset held with rd_en and a nonzero write pointer
      cyc(0, 1, 0, 6'b000101, M_ALL, 5'd0, 6'd0, 1, 1, 6'd0, 0, "reset0");
      cyc(0, 1, 0, 6'b000101, M_ALL, 5'd0, 6'd0, 1, 1, 6'd0, 0, "reset1");

      // Fill to 4 then drain
      idle(6'b000110, LAT);
      cyc(1, 0, 0, 6'b000110, M_ALL, 5'd0, 6'b000000, 0, 0, 6'd4, 0, "fill4");
      cyc(1, 1, 0, 6'b000110, M_ALL, 5'd1, 6'b000001, 0, 0, 6'd3, 0, "rd1");
      cyc(1, 1, 0, 6'b000110, M_ALL, 5'd2, 6'b000011, 0, 1, 6'd2, 0, "rd2");
      cyc(1, 1, 0, 6'b000110, M_ALL, 5'd3, 6'b000010, 0, 1, 6'd1, 0, "rd3");
      cyc(1, 1, 0, 6'b000110, M_ALL, 5'd4, 6'b000110, 1, 1, 6'd0, 0, "rd4");

      // Underflow: reads while empty are ignored and latch the flag
      for (int i = 0; i < 3; i++)
         cyc(1, 1, 0, 6'b000110, M_ALL, 5'd4, 6'b000110, 1, 1, 6'd0, 1, "uf_set");
      cyc(1, 1, 1, 6'b000110, M_ALL, 5'd4, 6'b000110, 1, 1, 6'd0, 1, "uf_set_wins");
      cyc(1, 0, 1, 6'b000110, M_ALL, 5'd4, 6'b000110, 1, 1, 6'd0, 0, "uf_clr");
      cyc(1, 0, 0, 6'b000110, M_ALL, 5'd4, 6'b000110, 1, 1, 6'd0, 0, "uf_stay0");

      // Mid-operation reset, then full level with write pointer 32 ahead
      cyc(0, 1, 1, 6'b110000, M_ALL, 5'd0, 6'd0, 1, 1, 6'd0, 0, "reset_mid");
      idle(6'b110000, LAT);
      cyc(1, 0, 0, 6'b110000, M_ALL, 5'd0, 6'd0, 0, 0, 6'd32, 0, "full_level");

      // 64 reads with the write pointer kept 32 ahead of the new read count
      for (int k = 1; k <= 64; k++) begin
         m = (LAT == 0) ? M_ALL : 6'b101111;
         cyc(1, 1, 0, gray((k + 32) % 64), m, 5'(k % 32), gray(k % 64), 0, 0, 6'd32, 0, "wrap");
      end
      idle(gray(32), LAT);

      // Level 1, then read and write advance on the same edge
      idle(gray(1), LAT);
      cyc(1, 0, 0, gray(1), M_ALL, 5'd0, 6'd0, 0, 1, 6'd1, 0, "lvl1");
`ifdef RD_INT_SYNC_EN
      cyc(1, 1, 0, gray(2), M_ALL, 5'd1, gray(1), 1, 1, 6'd0, 0, "simul_rd");
      cyc(1, 0, 0, gray(2), M_ALL, 5'd1, gray(1), 1, 1, 6'd0, 0, "simul_lag1");
      cyc(1, 0, 0, gray(2), M_ALL, 5'd1, gray(1), 0, 1, 6'd1, 0, "simul_lag2");
`else
      cyc(1, 1, 0, gray(2), M_ALL, 5'd1, gray(1), 0, 1, 6'd1, 0, "simul");
      cyc(1, 0, 0, gray(2), M_ALL, 5'd1, gray(1), 0, 1, 6'd1, 0, "simul_hold");
`endif

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge rd_clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
